fft_addr_gen: RTL and testbench
===============================

Name: fft_addr_gen

Overview:
- Radix-2 DIF butterfly address generator, sitting between the FFT sequencer and the ping-pong data SRAM / butterfly datapath.
- Issues one butterfly per cycle: a top/bottom read address pair and a twiddle index.
- Delays the same addresses by the butterfly latency to produce write-back addresses, and flips SRAM banks between stages.
- Each stage fully drains before the next one starts, so there are no read-after-write hazards.

Parameters:
- BF_LATENCY, 3: cycles from a read issue to the write-back of that butterfly's results; legal range 1..8.
- ADDR_W, 10: SRAM address width; supports up to 1024 points.

Ports:
- clk  input  1  clock
- i_reset  input  1  synchronous, active-high reset
- i_start  input  1  start pulse; sampled only in IDLE
- i_point_configuration  input  3  N = 2^(cfg+3), so 8..1024 points; latched on start
- i_stall  input  1  holds issue for this cycle
- o_busy  output  1  high in every state other than IDLE
- o_rd_valid  output  1  read pair valid this cycle
- o_rd_bank  output  1  bank being read
- o_rd_addr_top  output  ADDR_W  butterfly top read address
- o_rd_addr_bot  output  ADDR_W  butterfly bottom read address
- o_twiddle_idx  output  ADDR_W-1  twiddle index k, meaning W_N^k
- o_wr_valid  output  1  write pair valid this cycle
- o_wr_bank  output  1  bank being written; always ~o_rd_bank
- o_wr_addr_top  output  ADDR_W  top write-back address
- o_wr_addr_bot  output  ADDR_W  bottom write-back address
- o_stage  output  4  current stage index
- o_stage_done  output  1  one-cycle pulse at the end of each stage
- o_fft_done  output  1  one-cycle pulse when the last stage ends

Behaviour:
- Reset: all outputs 0 (o_wr_bank = 1), state IDLE, counters 0, write pipe cleared. Reset mid-operation aborts immediately with no done pulse.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on i_start. On that edge: latch L = cfg+3, stage s=0, j=0. While not IDLE, i_start is ignored.
- RUN, per cycle:
  - o_rd_valid = !i_stall (combinational from registered j and s).
  - With h = N>>(s+1):
    - top = ((j>>log2h)<<(log2h+1)) | (j & (h-1))
    - bot = top + h
    - twiddle = (j & (h-1)) << s
  - j increments on each non-stalled cycle.
  - On a non-stalled issue with j = N/2-1: j <= 0 and go to DRAIN.
- Stall: i_stall has effect only in RUN; it holds j and drops o_rd_valid. The write pipe keeps shifting regardless.
- Write pipe: BF_LATENCY-deep shift of {valid, top, bot}. o_wr_* equals the o_rd_* values from BF_LATENCY cycles earlier.
- DRAIN: lasts exactly BF_LATENCY cycles, counted by a drain counter; after that the write pipe is empty. On the last DRAIN cycle:
  - o_stage_done = 1.
  - o_rd_bank toggles on the exit edge.
  - If s = L-1, go to DONE; otherwise s <= s+1 and go to RUN.
- DONE: o_fft_done = 1 for one cycle, then IDLE.
- Cycle count: with no stalls, each stage occupies N/2 + BF_LATENCY cycles.
- Width rules: all shifts are done in ADDR_W bits; log2h = L-1-s. Stage s uses h = 1 at s = L-1 (no mask bits).
- Final bank: after an odd L, o_rd_bank ends at 1 and results are in bank 1; the bank is held until the next start.

Decomposition:
- Package fft_pkg holds:
  - the state enum typedef;
  - the ADDR_W default and MAX_LOG2N = 10;
  - a function cfg_to_log2n.
- One sub-module, fft_wb_delay: a parameterised shift register (depth BF_LATENCY) carrying {valid, top, bot}.

Test Plan:
- N=8 (cfg=0), BF_LATENCY=3, no stall. Required response:
  - stage 0: top 0,1,2,3; bot 4,5,6,7; twiddle 0,1,2,3.
  - stage 1: top 0,1,4,5; bot 2,3,6,7; twiddle 0,2,0,2.
  - stage 2: top 0,2,4,6; bot 1,3,5,7; twiddle 0.
  - o_fft_done pulses 21 cycles after the RUN entry; final o_rd_bank = 1.
- Write-back tracking, N=8: every o_wr pair equals the o_rd pair from 3 cycles earlier, and o_wr_bank = ~o_rd_bank throughout.
- Stall in stage 1, cycle 2, held for 2 cycles:
  - j holds and o_rd_valid is 0 for exactly 2 cycles;
  - the address sequence is unchanged;
  - the stage lengthens by 2; o_fft_done arrives at cycle 23.
- N=1024 (cfg=7), BF_LATENCY=1:
  - 10 stages of 513 cycles each;
  - last-stage bot = top+1;
  - stage 0 twiddle sweeps 0..511;
  - final bank = 0.
- i_reset asserted during DRAIN of stage 1: next cycle all outputs are 0 and state is IDLE; a following i_start restarts cleanly at stage 0, j=0, bank 0.
- i_start pulsed during RUN is ignored; o_stage and the address sequence are unaffected.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and helpers for the radix-2 DIF FFT address generator.
// Stage count L is derived from the 3-bit point configuration (N = 2^(cfg+3)).
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int ADDR_W_DEFAULT = 10;
  localparam int MAX_LOG2N      = 10;

  function automatic logic [3:0] cfg_to_log2n(input logic [2:0] cfg);
    return {1'b0, cfg} + 4'd3;
  endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// Fixed-depth shift register that turns read-issue {valid, top, bot} into
// write-back addresses DEPTH cycles later; shifts every cycle, stall or not.
module fft_wb_delay #(
  parameter int DEPTH  = 3,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_top,
  input  logic [ADDR_W-1:0] in_bot,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_top,
  output logic [ADDR_W-1:0] out_bot
);

  localparam int W = 1 + 2 * ADDR_W;

  logic [W-1:0] head;
  assign head = {in_valid, in_top, in_bot};

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [W-1:0] stage_in;
      logic [W-1:0] data_reg;

      if (gi == 0) begin : g_head
        assign stage_in = head;
      end else begin : g_tail
        assign stage_in = g_stage[gi-1].data_reg;
      end

      always_ff @(posedge clk) begin
        if (srst) begin
          data_reg <= '0;
        end else begin
          data_reg <= stage_in;
        end
      end
    end
  endgenerate

  assign {out_valid, out_top, out_bot} = g_stage[DEPTH-1].data_reg;

endmodule

// File: rtl/fft_addr_gen.sv
// Radix-2 DIF butterfly address generator: one read pair + twiddle per cycle,
// delayed write-back pair, ping-pong bank flip after each fully drained stage.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int BF_LATENCY = 3,
  parameter int ADDR_W     = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [2:0]        i_point_configuration,
  input  logic              i_stall,
  output logic              o_busy,
  output logic              o_rd_valid,
  output logic              o_rd_bank,
  output logic [ADDR_W-1:0] o_rd_addr_top,
  output logic [ADDR_W-1:0] o_rd_addr_bot,
  output logic [ADDR_W-2:0] o_twiddle_idx,
  output logic              o_wr_valid,
  output logic              o_wr_bank,
  output logic [ADDR_W-1:0] o_wr_addr_top,
  output logic [ADDR_W-1:0] o_wr_addr_bot,
  output logic [3:0]        o_stage,
  output logic              o_stage_done,
  output logic              o_fft_done
);

  localparam logic [3:0] DRAIN_LAST = 4'(BF_LATENCY - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-2:0] j_reg, j_next;
  logic [3:0]        s_reg, s_next;
  logic [3:0]        l_reg, l_next;
  logic [3:0]        drain_reg, drain_next;
  logic              bank_reg, bank_next;

  logic              in_run;
  logic              rd_valid;
  logic              last_j;
  logic              last_drain;
  logic [3:0]        log2h;
  logic [ADDR_W-1:0] j_ext, h_val, half_n, low_full, top_c, bot_c;

  // Butterfly geometry: h = N >> (s+1) = 2^(L-1-s); j splits into group and offset.
  always_comb begin
    log2h    = l_reg - 4'd1 - s_reg;
    j_ext    = {1'b0, j_reg};
    h_val    = ADDR_W'(1) << log2h;
    half_n   = ADDR_W'(1) << (l_reg - 4'd1);
    low_full = j_ext & (h_val - ADDR_W'(1));
    top_c    = ((j_ext >> log2h) << (log2h + 4'd1)) | low_full;
    bot_c    = top_c + h_val;
  end

  assign in_run     = (state_reg == ST_RUN);
  assign rd_valid   = in_run && !i_stall;
  assign last_j     = (j_ext == half_n - ADDR_W'(1));
  assign last_drain = (state_reg == ST_DRAIN) && (drain_reg == DRAIN_LAST);

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_reg <= ST_IDLE;
      j_reg     <= '0;
      s_reg     <= '0;
      l_reg     <= '0;
      drain_reg <= '0;
      bank_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      j_reg     <= j_next;
      s_reg     <= s_next;
      l_reg     <= l_next;
      drain_reg <= drain_next;
      bank_reg  <= bank_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    j_next     = j_reg;
    s_next     = s_reg;
    l_next     = l_reg;
    drain_next = drain_reg;
    bank_next  = bank_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_start) begin
          state_next = ST_RUN;
          l_next     = cfg_to_log2n(i_point_configuration);
          s_next     = '0;
          j_next     = '0;
          drain_next = '0;
          bank_next  = 1'b0;
        end
      end
      ST_RUN: begin
        if (!i_stall) begin
          if (last_j) begin
            j_next     = '0;
            drain_next = '0;
            state_next = ST_DRAIN;
          end else begin
            j_next = j_reg + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (last_drain) begin
          drain_next = '0;
          bank_next  = ~bank_reg;
          if (s_reg == l_reg - 4'd1) begin
            state_next = ST_DONE;
          end else begin
            s_next     = s_reg + 4'd1;
            state_next = ST_RUN;
          end
        end else begin
          drain_next = drain_reg + 4'd1;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign o_busy        = (state_reg != ST_IDLE);
  assign o_rd_valid    = rd_valid;
  assign o_rd_bank     = bank_reg;
  assign o_rd_addr_top = in_run ? top_c : '0;
  assign o_rd_addr_bot = in_run ? bot_c : '0;
  assign o_twiddle_idx = in_run ? (ADDR_W-1)'(low_full << s_reg) : '0;
  assign o_wr_bank     = ~bank_reg;
  assign o_stage       = s_reg;
  assign o_stage_done  = last_drain;
  assign o_fft_done    = (state_reg == ST_DONE);

  fft_wb_delay #(
    .DEPTH  (BF_LATENCY),
    .ADDR_W (ADDR_W)
  ) u_wb_delay (
    .clk       (clk),
    .srst      (i_reset),
    .in_valid  (rd_valid),
    .in_top    (o_rd_addr_top),
    .in_bot    (o_rd_addr_bot),
    .out_valid (o_wr_valid),
    .out_top   (o_wr_addr_top),
    .out_bot   (o_wr_addr_bot)
  );

endmodule

// File: tb/tb_fft_addr_gen.sv
// Scoreboard bench for fft_addr_gen: a per-run reference model queues every
// expected read/write/stage/done event; a negedge monitor pops and compares.
module tb_fft_addr_gen;

  localparam int AW       = 10;
  localparam int PLAN_SZ  = 16384;
  localparam int NO_ABORT = 1 << 30;

  typedef struct {
    int cyc;
    int stage;
    int top;
    int bot;
    int tw;
    int bank;
  } ev_t;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_start;
  logic       i_stall;
  logic [2:0] i_cfg;
  logic       sel;

  logic          busy[2], rd_valid[2], rd_bank[2], wr_valid[2], wr_bank[2];
  logic          stage_done[2], fft_done[2];
  logic [AW-1:0] rd_top[2], rd_bot[2], wr_top[2], wr_bot[2];
  logic [AW-2:0] tw[2];
  logic [3:0]    stage[2];

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  bit  plan[PLAN_SZ];
  ev_t rd_q[$];
  ev_t wr_q[$];
  ev_t sd_q[$];
  ev_t fd_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: BF_LATENCY=3, instance 1: BF_LATENCY=1; sel picks the one under test.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      fft_addr_gen #(
        .BF_LATENCY ((gi == 0) ? 3 : 1),
        .ADDR_W     (AW)
      ) dut (
        .clk                   (clk),
        .i_reset               (i_reset),
        .i_start               (i_start && (sel == 1'(gi))),
        .i_point_configuration (i_cfg),
        .i_stall               (i_stall),
        .o_busy                (busy[gi]),
        .o_rd_valid            (rd_valid[gi]),
        .o_rd_bank             (rd_bank[gi]),
        .o_rd_addr_top         (rd_top[gi]),
        .o_rd_addr_bot         (rd_bot[gi]),
        .o_twiddle_idx         (tw[gi]),
        .o_wr_valid            (wr_valid[gi]),
        .o_wr_bank             (wr_bank[gi]),
        .o_wr_addr_top         (wr_top[gi]),
        .o_wr_addr_bot         (wr_bot[gi]),
        .o_stage               (stage[gi]),
        .o_stage_done          (stage_done[gi]),
        .o_fft_done            (fft_done[gi])
      );
    end
  endgenerate

  task automatic check(input string name, input bit ok, input string detail);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Monitor: every DUT output event must match the head of its queue.
  always @(negedge clk) begin
    int  d;
    ev_t e;
    d = sel ? 1 : 0;
    if (rd_valid[d]) begin
      if (rd_q.size() == 0) begin
        check("rd_extra", 1'b0, $sformatf("got read top=%0d at cyc=%0d, required none", rd_top[d], cyc));
      end else begin
        e = rd_q.pop_front();
        check("rd_pair", cyc == e.cyc && stage[d] == e.stage && rd_top[d] == e.top &&
              rd_bot[d] == e.bot && tw[d] == e.tw && rd_bank[d] == e.bank,
              $sformatf("got cyc=%0d st=%0d top=%0d bot=%0d tw=%0d bank=%0d required cyc=%0d st=%0d top=%0d bot=%0d tw=%0d bank=%0d",
                        cyc, stage[d], rd_top[d], rd_bot[d], tw[d], rd_bank[d],
                        e.cyc, e.stage, e.top, e.bot, e.tw, e.bank));
      end
    end
    if (wr_valid[d]) begin
      if (wr_q.size() == 0) begin
        check("wr_extra", 1'b0, $sformatf("got write top=%0d at cyc=%0d, required none", wr_top[d], cyc));
      end else begin
        e = wr_q.pop_front();
        check("wr_pair", cyc == e.cyc && wr_top[d] == e.top && wr_bot[d] == e.bot && wr_bank[d] == e.bank,
              $sformatf("got cyc=%0d top=%0d bot=%0d bank=%0d required cyc=%0d top=%0d bot=%0d bank=%0d",
                        cyc, wr_top[d], wr_bot[d], wr_bank[d], e.cyc, e.top, e.bot, e.bank));
      end
    end
    if (stage_done[d]) begin
      if (sd_q.size() == 0) begin
        check("stage_done_extra", 1'b0, $sformatf("got pulse at cyc=%0d, required none", cyc));
      end else begin
        e = sd_q.pop_front();
        check("stage_done", cyc == e.cyc && stage[d] == e.stage,
              $sformatf("got cyc=%0d st=%0d required cyc=%0d st=%0d", cyc, stage[d], e.cyc, e.stage));
      end
    end
    if (fft_done[d]) begin
      if (fd_q.size() == 0) begin
        check("fft_done_extra", 1'b0, $sformatf("got pulse at cyc=%0d, required none", cyc));
      end else begin
        e = fd_q.pop_front();
        check("fft_done", cyc == e.cyc && stage[d] == e.stage && rd_bank[d] == e.bank && busy[d],
              $sformatf("got cyc=%0d st=%0d bank=%0d busy=%0d required cyc=%0d st=%0d bank=%0d busy=1",
                        cyc, stage[d], rd_bank[d], busy[d], e.cyc, e.stage, e.bank));
      end
    end
    if (busy[d]) begin
      check("bank_pair", wr_bank[d] == !rd_bank[d],
            $sformatf("got wr_bank=%0d rd_bank=%0d required complementary", wr_bank[d], rd_bank[d]));
    end
  end

  // Reference model: walk stages and butterflies with plain arithmetic,
  // skipping stalled cycles, and queue each event with its absolute cycle.
  task automatic build_model(input int t0, input int l, input int bl, input int abort_rel,
                             output int fd_rel);
    int  n;
    int  t;
    int  bank;
    int  h;
    ev_t e;
    n    = 1 << l;
    t    = t0;
    bank = 0;
    for (int s = 0; s < l; s++) begin
      h = n >> (s + 1);
      for (int j = 0; j < n / 2; j++) begin
        while ((t - t0) < PLAN_SZ && plan[t - t0]) t++;
        e.cyc   = t;
        e.stage = s;
        e.top   = (j / h) * 2 * h + (j % h);
        e.bot   = e.top + h;
        e.tw    = (j % h) * (1 << s);
        e.bank  = bank;
        if (t - t0 < abort_rel) rd_q.push_back(e);
        e.cyc  = t + bl;
        e.bank = 1 - bank;
        if (t + bl - t0 < abort_rel) wr_q.push_back(e);
        t++;
      end
      t += bl;
      e.cyc   = t - 1;
      e.stage = s;
      if (t - 1 - t0 < abort_rel) sd_q.push_back(e);
      bank = 1 - bank;
    end
    e.cyc   = t;
    e.stage = l - 1;
    e.bank  = bank;
    if (t - t0 < abort_rel) fd_q.push_back(e);
    fd_rel = t - t0;
  endtask

  task automatic run_fft(input bit use_dut1, input int cfg, input int stall_pct,
                         input int glitch_rel, input int abort_rel, input bit stage1_stall);
    int t0;
    int fd_rel;
    int end_rel;
    int rel;
    int l;
    int bl;
    int d;
    l  = cfg + 3;
    bl = use_dut1 ? 1 : 3;
    d  = use_dut1 ? 1 : 0;
    for (int r = 0; r < PLAN_SZ; r++) begin
      plan[r] = (stall_pct > 0) && ($urandom_range(0, 99) < stall_pct);
    end
    if (stage1_stall) begin
      plan[(1 << (l - 1)) + bl + 2] = 1'b1;
      plan[(1 << (l - 1)) + bl + 3] = 1'b1;
    end
    @(posedge clk);
    #1;
    sel = use_dut1;
    t0  = cyc + 1;
    build_model(t0, l, bl, abort_rel, fd_rel);
    i_cfg   = 3'(cfg);
    i_start = 1'b1;
    i_stall = 1'b0;
    end_rel = (abort_rel < fd_rel) ? abort_rel : fd_rel + 2;
    rel     = -1;
    while (rel < end_rel) begin
      @(posedge clk);
      #1;
      rel     = cyc - t0;
      i_start = (rel == glitch_rel);
      i_stall = (rel < PLAN_SZ) ? plan[rel] : 1'b0;
      i_reset = (rel == abort_rel - 1);
    end
    @(negedge clk);
    if (abort_rel < fd_rel) begin
      check("abort_state",
            {busy[d], rd_valid[d], rd_bank[d], rd_top[d], rd_bot[d], tw[d], wr_valid[d], wr_bank[d],
             wr_top[d], wr_bot[d], stage[d], stage_done[d], fft_done[d]} ==
            {7'b0, {(3 * AW - 1){1'b0}}, 1'b1, {(2 * AW + 6){1'b0}}},
            $sformatf("got busy=%0d rv=%0d rb=%0d top=%0d wv=%0d wb=%0d st=%0d required idle zeros with wr_bank=1",
                      busy[d], rd_valid[d], rd_bank[d], rd_top[d], wr_valid[d], wr_bank[d], stage[d]));
    end else begin
      check("idle_after_done", !busy[d] && rd_bank[d] == 1'(l % 2),
            $sformatf("got busy=%0d bank=%0d required busy=0 bank=%0d", busy[d], rd_bank[d], l % 2));
    end
    check("queues_drained", rd_q.size() + wr_q.size() + sd_q.size() + fd_q.size() == 0,
          $sformatf("got pending rd=%0d wr=%0d sd=%0d fd=%0d required all 0",
                    rd_q.size(), wr_q.size(), sd_q.size(), fd_q.size()));
    rd_q.delete();
    wr_q.delete();
    sd_q.delete();
    fd_q.delete();
    i_stall = 1'b0;
    i_start = 1'b0;
    i_reset = 1'b0;
    $display("run dut_latency=%0d cfg=%0d stall_pct=%0d abort=%0d checks=%0d failures=%0d",
             bl, cfg, stall_pct, (abort_rel < fd_rel), checks, failures);
  endtask

  initial begin
    i_reset = 1'b1;
    i_start = 1'b0;
    i_stall = 1'b0;
    i_cfg   = 3'd0;
    sel     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("reset_state",
            {busy[d], rd_valid[d], rd_bank[d], rd_top[d], rd_bot[d], tw[d], wr_valid[d], wr_bank[d],
             wr_top[d], wr_bot[d], stage[d], stage_done[d], fft_done[d]} ==
            {7'b0, {(3 * AW - 1){1'b0}}, 1'b1, {(2 * AW + 6){1'b0}}},
            $sformatf("dut%0d got busy=%0d rv=%0d rb=%0d wv=%0d wb=%0d st=%0d required zeros with wr_bank=1",
                      d, busy[d], rd_valid[d], rd_bank[d], wr_valid[d], wr_bank[d], stage[d]));
    end

    run_fft(1'b0, 0, 0, -1, NO_ABORT, 1'b0);   // N=8 baseline, done 21 cycles after RUN entry
    run_fft(1'b0, 0, 0, -1, NO_ABORT, 1'b1);   // 2-cycle stall in stage 1, done at 23
    run_fft(1'b0, 0, 0, -1, 13, 1'b0);         // reset during stage-1 drain
    run_fft(1'b0, 0, 0, -1, NO_ABORT, 1'b0);   // clean restart after abort
    run_fft(1'b0, 1, 0, 2, NO_ABORT, 1'b0);    // start pulse during RUN is ignored
    run_fft(1'b1, 7, 0, -1, NO_ABORT, 1'b0);   // N=1024, latency 1
    for (int k = 0; k < 6; k++) begin
      run_fft(1'b0, $urandom_range(0, 4), 30, $urandom_range(1, 3), NO_ABORT, 1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      run_fft(1'b1, $urandom_range(0, 5), 25, -1, NO_ABORT, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
